// File: rtl/ook_frame_serializer.sv
// ============================================================================
// Module   : ook_frame_serializer
// Purpose  : Serialises one {ADDR, command} word into an OOK frame
//            (sync burst, 3-chip bit cells, trailing gap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ook_frame_serializer #(
    parameter int unsigned          TICKS_PER_CHIP = 4800,
    parameter int unsigned          ADDR_W         = 12,
    parameter logic [ADDR_W-1:0]    ADDR           = 12'hA5C,
    parameter int unsigned          SYNC_HIGH      = 2,
    parameter int unsigned          SYNC_LOW       = 4,
    parameter int unsigned          GAP_CHIPS      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] cmd,
    output logic       ook,
    output logic       busy,
    output logic       done,
    output logic       cmd_err
);

    localparam int unsigned c_WORD_W = ADDR_W + 8;
    localparam int unsigned c_TW     = (TICKS_PER_CHIP > 1) ? $clog2(TICKS_PER_CHIP) : 1;
    localparam int unsigned c_MAX_A  = (SYNC_HIGH > SYNC_LOW) ? SYNC_HIGH : SYNC_LOW;
    localparam int unsigned c_MAX_B  = (c_WORD_W > GAP_CHIPS) ? c_WORD_W : GAP_CHIPS;
    localparam int unsigned c_MAXC   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int unsigned c_CW     = $clog2(c_MAXC + 1);

    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICKS_PER_CHIP - 1);
    localparam logic [c_CW-1:0] c_SH_LAST   = c_CW'(SYNC_HIGH - 1);
    localparam logic [c_CW-1:0] c_SL_LAST   = c_CW'(SYNC_LOW - 1);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_WORD_W - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST  = c_CW'(GAP_CHIPS - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_SYNC_H = 3'd1;
    localparam logic [2:0] c_S_SYNC_L = 3'd2;
    localparam logic [2:0] c_S_BITS   = 3'd3;
    localparam logic [2:0] c_S_GAP    = 3'd4;

    logic [2:0]          r_state, w_state_nxt;
    logic [c_TW-1:0]     r_tick,  w_tick_nxt;
    logic [c_CW-1:0]     r_cnt,   w_cnt_nxt;
    logic [1:0]          r_sub,   w_sub_nxt;
    logic [c_WORD_W-1:0] r_word,  w_word_nxt;
    logic                r_ook, r_busy, r_done, r_cmd_err;
    logic                w_ook_nxt, w_busy_nxt, w_done_nxt, w_cmd_err_nxt;
    logic                w_wrap, w_accept, w_reject;
    logic [7:0]          w_code;

    assign w_wrap   = (r_tick == c_TICK_LAST);
    assign w_code   = 8'd1 << cmd;
    assign w_accept = (r_state == c_S_IDLE) && start && (cmd <= 3'd4);
    assign w_reject = (r_state == c_S_IDLE) && start && (cmd > 3'd4);

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_S_IDLE;
            r_tick    <= '0;
            r_cnt     <= '0;
            r_sub     <= '0;
            r_word    <= '0;
            r_ook     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sub     <= w_sub_nxt;
            r_word    <= w_word_nxt;
            r_ook     <= w_ook_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_cmd_err <= w_cmd_err_nxt;
        end
    end

    // Indices move only on a chip-counter wrap; r_cnt is the chip index in
    // the sync/gap phases and the bit index in BITS.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_cnt_nxt   = r_cnt;
        w_sub_nxt   = r_sub;
        w_word_nxt  = r_word;
        if (r_state != c_S_IDLE) begin
            w_tick_nxt = w_wrap ? '0 : r_tick + 1'b1;
        end
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_S_SYNC_H;
                    w_tick_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_sub_nxt   = '0;
                    w_word_nxt  = {ADDR, w_code};
                end
            end
            c_S_SYNC_H: begin
                if (w_wrap) begin
                    if (r_cnt == c_SH_LAST) begin
                        w_state_nxt = c_S_SYNC_L;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            c_S_SYNC_L: begin
                if (w_wrap) begin
                    if (r_cnt == c_SL_LAST) begin
                        w_state_nxt = c_S_BITS;
                        w_cnt_nxt   = '0;
                        w_sub_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            c_S_BITS: begin
                if (w_wrap) begin
                    if (r_sub == 2'd2) begin
                        w_sub_nxt  = '0;
                        w_word_nxt = {r_word[c_WORD_W-2:0], 1'b0};
                        if (r_cnt == c_BIT_LAST) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = (GAP_CHIPS == 0) ? c_S_IDLE : c_S_GAP;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else begin
                        w_sub_nxt = r_sub + 1'b1;
                    end
                end
            end
            c_S_GAP: begin
                if (w_wrap) begin
                    if (r_cnt == c_GAP_LAST) begin
                        w_state_nxt = c_S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered ook
    // lines up with the chip being entered (first sync chip right after accept).
    always_comb begin
        w_ook_nxt = 1'b0;
        case (w_state_nxt)
            c_S_SYNC_H: w_ook_nxt = 1'b1;
            c_S_BITS: begin
                case (w_sub_nxt)
                    2'd0:    w_ook_nxt = 1'b1;
                    2'd1:    w_ook_nxt = w_word_nxt[c_WORD_W-1];
                    default: w_ook_nxt = 1'b0;
                endcase
            end
            default: w_ook_nxt = 1'b0;
        endcase
        w_busy_nxt    = (w_state_nxt != c_S_IDLE);
        w_done_nxt    = (r_state != c_S_IDLE) && (w_state_nxt == c_S_IDLE);
        w_cmd_err_nxt = w_reject;
    end

    assign ook     = r_ook;
    assign busy    = r_busy;
    assign done    = r_done;
    assign cmd_err = r_cmd_err;

endmodule

`default_nettype wire

// File: tb/tb_ook_frame_serializer.sv
// ============================================================================
// Module   : tb_ook_frame_serializer
// Purpose  : Directed and random stimulus on two serializers (1 and 2 ticks
//            per chip) checked cycle-by-cycle against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ook_frame_serializer;

    localparam int          N_CH = 86;
    localparam logic [11:0] FAN_ADDR = 12'hA5C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic       ook_o[2];
    logic       busy_o[2];
    logic       done_o[2];
    logic       err_o[2];

    int errors = 0;
    int checks = 0;
    int tpc_of[2] = '{1, 2};

    always #5 clk = ~clk;

    ook_frame_serializer #(.TICKS_PER_CHIP(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd),
        .ook(ook_o[0]), .busy(busy_o[0]), .done(done_o[0]), .cmd_err(err_o[0])
    );

    ook_frame_serializer #(.TICKS_PER_CHIP(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd),
        .ook(ook_o[1]), .busy(busy_o[1]), .done(done_o[1]), .cmd_err(err_o[1])
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Chip value of a frame, straight from the frame layout
    function automatic logic chip_val(input logic [19:0] w, input int c);
        int b;
        int s;
        if (c < 2) return 1'b1;
        if (c < 6) return 1'b0;
        if (c < 66) begin
            b = (c - 6) / 3;
            s = (c - 6) % 3;
            if (s == 0) return 1'b1;
            if (s == 1) return w[19-b];
            return 1'b0;
        end
        return 1'b0;
    endfunction

    // Frame-level reference: each DUT is either idle or k cycles into a frame
    bit         m_act[2];
    int         m_k[2];
    logic [19:0] m_word[2];
    logic       e_ook[2], e_busy[2], e_done[2], e_err[2];

    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                e_done[d] = 1'b0;
                e_err[d]  = 1'b0;
                if (reset) begin
                    m_act[d] = 1'b0;
                end else if (m_act[d]) begin
                    m_k[d]++;
                    if (m_k[d] == N_CH * tpc_of[d]) begin
                        m_act[d]  = 1'b0;
                        e_done[d] = 1'b1;
                    end
                end else if (start) begin
                    if (cmd <= 3'd4) begin
                        m_act[d]  = 1'b1;
                        m_k[d]    = 0;
                        m_word[d] = {FAN_ADDR, 8'd1 << cmd};
                    end else begin
                        e_err[d] = 1'b1;
                    end
                end
                e_busy[d] = m_act[d];
                e_ook[d]  = m_act[d] ? chip_val(m_word[d], m_k[d] / tpc_of[d]) : 1'b0;
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("ook[%0d]", d),     ook_o[d],  e_ook[d]);
                check($sformatf("busy[%0d]", d),    busy_o[d], e_busy[d]);
                check($sformatf("done[%0d]", d),    done_o[d], e_done[d]);
                check($sformatf("cmd_err[%0d]", d), err_o[d],  e_err[d]);
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (!busy_o[0] && !busy_o[1]) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle: busy still high after 1000 cycles");
        end
    endtask

    // Pulse start and observe DUT d for ncyc cycles after the accept edge
    task automatic run_frame(input logic [2:0] c, input int d, input int ncyc,
                             output int bcnt, output int dcyc, output int dn,
                             output int ecnt, output int ohigh, output logic [85:0] chips);
        bcnt = 0; dcyc = 0; dn = 0; ecnt = 0; ohigh = 0; chips = '0;
        @(negedge clk);
        start = 1'b1;
        cmd   = c;
        @(posedge clk);
        for (int i = 1; i <= ncyc; i++) begin
            #1;
            if (busy_o[d]) bcnt++;
            if (ook_o[d]) ohigh++;
            if (err_o[d]) ecnt++;
            if (done_o[d]) begin
                dn++;
                if (dcyc == 0) dcyc = i;
            end
            if (((i - 1) % tpc_of[d] == 0) && ((i - 1) / tpc_of[d] < N_CH))
                chips[85 - (i - 1) / tpc_of[d]] = ook_o[d];
            @(negedge clk);
            start = 1'b0;
            cmd   = 3'($urandom_range(0, 7));
            @(posedge clk);
        end
    endtask

    initial begin
        int bcnt, dcyc, dn, ecnt, ohigh;
        logic [85:0] chips;
        logic [85:0] golden;
        logic [85:0] expv;
        logic [19:0] w;
        bit seen;

        golden = {6'b110000, 12'b110100110100, 12'b100110100110, 12'b110110100100,
                  24'b100100100100100100100110, 20'b0};

        // Reset
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ook", ook_o[1], 1'b0);
        check("rst_busy", busy_o[1], 1'b0);
        check("rst_done", done_o[1], 1'b0);
        check("rst_cmd_err", err_o[1], 1'b0);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cmd   = 3'd2;
        @(posedge clk);
        #1;
        check("first_ook", ook_o[1], 1'b1);
        check("first_busy", busy_o[1], 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Golden frame at two ticks per chip
        run_frame(3'd0, 1, 200, bcnt, dcyc, dn, ecnt, ohigh, chips);
        check("gold_busy_len", bcnt, 172);
        check("gold_done_cyc", dcyc, 173);
        check("gold_done_cnt", dn, 1);
        check("gold_chips", chips, golden);
        wait_idle();

        // Light command at one tick per chip
        run_frame(3'd4, 0, 100, bcnt, dcyc, dn, ecnt, ohigh, chips);
        check("light_busy_len", bcnt, 86);
        check("light_done_cyc", dcyc, 87);
        check("light_cmd_field", chips[43:20], 24'b100100100110100100100100);
        wait_idle();

        // Illegal command
        run_frame(3'd6, 1, 200, bcnt, dcyc, dn, ecnt, ohigh, chips);
        check("illegal_err_cnt", ecnt, 1);
        check("illegal_busy", bcnt, 0);
        check("illegal_ook", ohigh, 0);
        check("illegal_done", dn, 0);
        wait_idle();

        // Starts while busy are ignored; restart in the done cycle
        @(negedge clk);
        start = 1'b1;
        cmd   = 3'd3;
        @(posedge clk);
        dcyc = 0;
        seen = 1'b0;
        for (int i = 1; i <= 400 && !seen; i++) begin
            #1;
            if (done_o[1]) begin
                seen  = 1'b1;
                dcyc  = i;
                start = 1'b1;
                cmd   = 3'd1;
            end else begin
                @(negedge clk);
                start = (i == 21) || (i == 101);
                cmd   = (i == 21) ? 3'd5 : 3'd0;
                @(posedge clk);
            end
        end
        check("busy_done_cyc", dcyc, 173);
        @(posedge clk);
        #1;
        check("b2b_ook", ook_o[1], 1'b1);
        check("b2b_busy", busy_o[1], 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Abort at chip 30
        @(negedge clk);
        start = 1'b1;
        cmd   = 3'd2;
        @(posedge clk);
        for (int i = 1; i < 61; i++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ook", ook_o[1], 1'b0);
        check("abort_busy", busy_o[1], 1'b0);
        check("abort_done", done_o[1], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(3'd1, 1, 180, bcnt, dcyc, dn, ecnt, ohigh, chips);
        w = {FAN_ADDR, 8'h02};
        for (int c = 0; c < N_CH; c++) expv[85 - c] = chip_val(w, c);
        check("abort_new_len", bcnt, 172);
        check("abort_new_done", dcyc, 173);
        check("abort_new_chips", chips, expv);
        wait_idle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            cmd   = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
